// File: rtl/frogger_video_pkg.sv
// Shared types and helpers for the frogger video/MMIO block: timing totals,
// register offsets and pixel-format expansion.
package frogger_video_pkg;

    typedef enum logic {
        PIX_RGB332 = 1'b0,
        PIX_RGB888 = 1'b1
    } pix_fmt_e;

    localparam int REG_KEY    = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_CTRL   = 2;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bit replication makes full-scale codes map to 8'hFF and zero to 8'h00.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel divider and h/v raster counters with raw sync, active-area and
// start-of-vblank indications.
module vga_timing_gen
    import frogger_video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2,
    localparam int H_TOT   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOT   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOT + 1),
    localparam int VW      = $clog2(V_TOT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active_raw,
    output logic          in_vblank,
    output logic          vblank_start
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div_reg;
    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;
    logic          tick;

    assign tick = (div_reg == DW'(PIX_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) begin
                if (h_reg == HW'(H_TOT - 1)) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == VW'(V_TOT - 1)) ? '0 : v_reg + 1'b1;
                end else begin
                    h_reg <= h_reg + 1'b1;
                end
            end
        end
    end

    assign h            = h_reg;
    assign v            = v_reg;
    assign hsync_raw    = !((h_reg >= HW'(H_ACTIVE + H_FP)) && (h_reg < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw    = !((v_reg >= VW'(V_ACTIVE + V_FP)) && (v_reg < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_raw   = (h_reg < HW'(H_ACTIVE)) && (v_reg < VW'(V_ACTIVE));
    assign in_vblank    = (v_reg >= VW'(V_ACTIVE));
    assign vblank_start = tick && (h_reg == '0) && (v_reg == VW'(V_ACTIVE));

endmodule

// File: rtl/frogger_video_mmio.sv
// CPU data-port decoder for framebuffer, keyboard and status/control registers,
// plus VGA scan-out of the displayed page with vblank-synchronous page flips.
module frogger_video_mmio
    import frogger_video_pkg::*;
#(
    parameter int               BUS      = 32,
    parameter int               H_ACTIVE = 640,
    parameter int               H_FP     = 16,
    parameter int               H_SYNC   = 96,
    parameter int               H_BP     = 48,
    parameter int               V_ACTIVE = 480,
    parameter int               V_FP     = 10,
    parameter int               V_SYNC   = 2,
    parameter int               V_BP     = 33,
    parameter int               PIX_DIV  = 2,
    parameter int               PAGES    = 2,
    parameter pix_fmt_e         PIX_FMT  = PIX_RGB332,
    parameter logic [BUS-1:0]   FB_BASE  = 32'h0001_0000,
    parameter logic [BUS-1:0]   REG_BASE = 32'h0000_FFF0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BUS-1:0] mem_addr,
    input  logic [BUS-1:0] mem_wdata,
    input  logic           mem_re,
    input  logic           mem_we,
    output logic [BUS-1:0] mem_rdata,
    input  logic [BUS-1:0] keyboard_data,
    output logic [7:0]     R,
    output logic [7:0]     G,
    output logic [7:0]     B,
    output logic           hsync,
    output logic           vsync,
    output logic           blank_n
);

    localparam int H_TOT      = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT      = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW         = $clog2(H_TOT + 1);
    localparam int VW         = $clog2(V_TOT + 1);
    localparam int PAGE_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int FB_WORDS   = PAGES * PAGE_WORDS;
    localparam int FBAW       = $clog2(FB_WORDS);
    localparam int PIX_BITS   = (PIX_FMT == PIX_RGB888) ? 24 : 8;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hsync_raw, vsync_raw, active_raw, in_vblank, vblank_start;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_DIV(PIX_DIV)
    ) u_tg (
        .clk(clk), .reset(reset), .h(h_cnt), .v(v_cnt),
        .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .active_raw(active_raw),
        .in_vblank(in_vblank), .vblank_start(vblank_start)
    );

    logic                fb_hit, key_hit, status_hit, ctrl_hit;
    logic [FBAW-1:0]     fb_off, vid_idx;
    logic [PIX_BITS-1:0] ram [FB_WORDS];
    logic [PIX_BITS-1:0] cpu_pix_reg, vid_pix_reg;
    logic [1:0]          disp_page_reg, draw_page_reg, draw_page_next;
    logic [BUS-5:0]      frame_cnt_reg;
    logic [BUS-1:0]      key_sample_reg, key_reg;
    logic                key_new_reg;
    logic                fb_sel_reg;
    logic [BUS-1:0]      reg_rdata_reg, reg_rdata_next;
    logic                hsync_d_reg, vsync_d_reg, active_d_reg;
    logic [23:0]         pix_rgb;
    logic                unused_wdata;

    assign fb_hit     = (mem_addr >= FB_BASE) && (mem_addr < FB_BASE + BUS'(FB_WORDS));
    assign fb_off     = FBAW'(mem_addr - FB_BASE);
    assign key_hit    = (mem_addr == REG_BASE + BUS'(REG_KEY));
    assign status_hit = (mem_addr == REG_BASE + BUS'(REG_STATUS));
    assign ctrl_hit   = (mem_addr == REG_BASE + BUS'(REG_CTRL));
    assign unused_wdata = ^mem_wdata[BUS-1:PIX_BITS];

    assign draw_page_next = (int'(mem_wdata[1:0]) >= PAGES) ? 2'(PAGES - 1) : mem_wdata[1:0];

    always_comb begin
        reg_rdata_next = '0;
        if (key_hit)
            reg_rdata_next = key_reg;
        else if (status_hit)
            reg_rdata_next = {key_new_reg, in_vblank, draw_page_reg, frame_cnt_reg};
        else if (ctrl_hit)
            reg_rdata_next = {{(BUS-2){1'b0}}, draw_page_reg};
    end

    // CPU port is read-first, so a simultaneous read/write returns the old pixel.
    always_ff @(posedge clk) begin
        if (mem_we && fb_hit)
            ram[fb_off] <= mem_wdata[PIX_BITS-1:0];
        cpu_pix_reg <= ram[fb_off];
    end

    assign vid_idx = FBAW'(int'(disp_page_reg) * PAGE_WORDS + int'(v_cnt) * H_ACTIVE + int'(h_cnt));

    always_ff @(posedge clk) begin
        vid_pix_reg <= ram[vid_idx];
    end

    generate
        if (PIX_FMT == PIX_RGB888) begin : g_rgb888
            assign pix_rgb = vid_pix_reg[23:0];
        end else begin : g_rgb332
            assign pix_rgb = rgb332_expand(vid_pix_reg[7:0]);
        end
    endgenerate

    assign mem_rdata = fb_sel_reg ? BUS'(cpu_pix_reg) : reg_rdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sample_reg <= '0;
            key_reg        <= '0;
            key_new_reg    <= 1'b0;
            draw_page_reg  <= '0;
            disp_page_reg  <= '0;
            frame_cnt_reg  <= '0;
            fb_sel_reg     <= 1'b0;
            reg_rdata_reg  <= '0;
            hsync_d_reg    <= 1'b1;
            vsync_d_reg    <= 1'b1;
            active_d_reg   <= 1'b0;
            hsync          <= 1'b1;
            vsync          <= 1'b1;
            blank_n        <= 1'b0;
            R              <= '0;
            G              <= '0;
            B              <= '0;
        end else begin
            key_sample_reg <= keyboard_data;
            // A new key code outranks a clearing KEY read in the same cycle.
            if (key_sample_reg != key_reg) begin
                key_reg     <= key_sample_reg;
                key_new_reg <= 1'b1;
            end else if (mem_re && key_hit) begin
                key_new_reg <= 1'b0;
            end
            if (mem_we && ctrl_hit)
                draw_page_reg <= draw_page_next;
            if (vblank_start) begin
                disp_page_reg <= draw_page_reg;
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            fb_sel_reg    <= mem_re && fb_hit;
            reg_rdata_reg <= mem_re ? reg_rdata_next : '0;
            // Sync/blank ride alongside the RAM read so all outputs stay aligned.
            hsync_d_reg   <= hsync_raw;
            vsync_d_reg   <= vsync_raw;
            active_d_reg  <= active_raw;
            hsync         <= hsync_d_reg;
            vsync         <= vsync_d_reg;
            blank_n       <= active_d_reg;
            R             <= active_d_reg ? pix_rgb[23:16] : 8'h00;
            G             <= active_d_reg ? pix_rgb[15:8]  : 8'h00;
            B             <= active_d_reg ? pix_rgb[7:0]   : 8'h00;
        end
    end

endmodule

// File: doc/frogger_video_mmio.md
Name: frogger_video_mmio

Overview:
Memory-mapped video and I/O subsystem that replaces the flat data memory on the processor's data port. It decodes a multi-page framebuffer, a latched keyboard register, and status/control registers. It also generates parametrised VGA timing and scans the selected framebuffer page out to R, G and B. Page flips are double-buffered and take effect only at vertical blank.

Parameters:
BUS, 32, CPU data and address width
H_ACTIVE / H_FP / H_SYNC / H_BP, 640/16/96/48, horizontal timing in pixels
V_ACTIVE / V_FP / V_SYNC / V_BP, 480/10/2/33, vertical timing in lines
PIX_DIV, 2, clk cycles per pixel (≥1)
PAGES, 2, framebuffer pages (1..4)
PIX_FMT, 0, 0 = RGB332 (8 bits stored), 1 = RGB888 (24 bits stored)
FB_BASE, 32'h0001_0000, word address of page 0 pixel (0,0)
REG_BASE, 32'h0000_FFF0, base of the register block

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
mem_addr  in  BUS  CPU word address
mem_wdata  in  BUS  CPU write data
mem_re  in  1  CPU read strobe
mem_we  in  1  CPU write strobe
mem_rdata  out  BUS  CPU read data, valid 1 clk after mem_re
keyboard_data  in  BUS  raw keyboard code
R, G, B  out  8 each  pixel colour
hsync, vsync  out  1  active-low sync
blank_n  out  1  high during the active area

Behaviour:
- Single clock domain. Reset is synchronous and active-high; this is already decided.
- Reset values:
  - counters h, v and the pixel divider = 0
  - R, G, B = 0; blank_n = 0; hsync = vsync = 1
  - mem_rdata = 0; disp_page = draw_page = 0; frame_cnt = 0; key_new = 0; key_reg = 0
- Pixel tick:
  - divider counts 0..PIX_DIV-1; tick asserts when it equals PIX_DIV-1.
  - h advances on tick, wrapping at H_TOTAL-1 to 0.
  - v advances when h wraps, wrapping at V_TOTAL-1 to 0.
- Sync and blank:
  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is defined the same way on v.
  - active area = h<H_ACTIVE and v<V_ACTIVE.
- Scan-out pipeline, 2 clk:
  - stage 0 computes the framebuffer index disp_page*H_ACTIVE*V_ACTIVE + v*H_ACTIVE + h.
  - stage 1 performs the synchronous RAM read.
  - stage 2 registers R, G, B, hsync, vsync and blank_n together.
  - all video outputs are aligned. R, G, B are forced to 0 when not active.
- Pixel formats:
  - RGB332 expands by bit replication: R = {p[7:5],p[7:5],p[7:6]}, G = {p[4:2],p[4:2],p[4:3]}, B = {p[1:0] repeated 4 times}.
  - RGB888 uses R=p[23:16], G=p[15:8], B=p[7:0].
- Address decode, word addresses:
  - FB region: FB_BASE .. FB_BASE + PAGES*H_ACTIVE*V_ACTIVE - 1.
    - a write stores mem_wdata[PIX_BITS-1:0].
    - a read returns the pixel zero-extended.
  - REG_BASE+0 KEY (RO): returns key_reg; a read clears key_new.
  - REG_BASE+1 STATUS (RO): {key_new, in_vblank, draw_page[1:0], frame_cnt[BUS-5:0]}, MSB first. in_vblank = v≥V_ACTIVE.
  - REG_BASE+2 CTRL (RW): bits[1:0] = draw_page, the requested display page.
    - a write of a value ≥PAGES is clamped to PAGES-1.
  - Any other address: writes are ignored and reads return 0.
  - If mem_re and mem_we are both high, the write is performed and the read returns the pre-write data.
- CPU framebuffer port and video port are independent ports of a true dual-port RAM. On a same-address collision the video port reads the old data.
- Keyboard:
  - keyboard_data is registered every clk.
  - when the registered value differs from key_reg, key_reg is updated and key_new is set.
  - set and a clearing KEY read in the same clk: set wins.
- Page flip:
  - at the tick where h=0 and v=V_ACTIVE (start of vblank), disp_page ← draw_page and frame_cnt increments (wraps).
  - a CTRL write during active video does not affect the current frame.
- Reset asserted mid-frame returns all state to the reset values on the next edge. RAM contents are not cleared.

Decomposition:
- Package frogger_video_pkg holds:
  - H_TOTAL and V_TOTAL derivation functions
  - register offset localparams: KEY=0, STATUS=1, CTRL=2
  - pix_fmt_e enum
  - the rgb332_expand function
- Sub-module vga_timing_gen: divider, h/v counters, raw hsync/vsync/active and the vblank_start pulse. Parametrised by the timing parameters and PIX_DIV.
- Framebuffer RAM is inferred inside the top module.

Test Plan:
1. Bench configuration: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, PIX_DIV=1, PAGES=2.
   - Reset release: hsync high for exactly 5 clk then low for 2, period 8.
   - vsync low for 8 clk every 48 clk.
   - blank_n high 4 of every 8 clk during lines 0..2.
   - all video outputs lag the counters by 2 clk.
2. Write 8'hE0 to FB_BASE+0 and 8'h03 to FB_BASE+1 (RGB332).
   - next frame, pixel 0 gives R=FF, G=00, B=00.
   - pixel 1 gives R=00, G=00, B=FF.
   - readback of FB_BASE+1 returns 32'h3 after 1 clk.
3. Fill page 1 with 8'h1C, then write CTRL=1 mid-active.
   - the current frame still shows page 0.
   - from the first pixel after the next vblank, G=FF.
   - STATUS frame_cnt has incremented by 1.
4. Drive keyboard_data=32'h1D.
   - STATUS[31]=1 within 2 clk.
   - KEY read returns 32'h1D and clears the flag.
   - keyboard change in the same clk as a KEY read leaves the flag = 1.
5. CTRL write of 3 with PAGES=2 reads back 1.
   - write to REG_BASE+5 is ignored; read of it returns 0.
   - read of FB_BASE+24 (out of range) returns 0.
6. Assert reset for 1 clk mid-frame: next clk gives h=v=0, hsync=vsync=1, RGB=0 and disp_page=0, while framebuffer data is retained.
